mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
- Single-channel block-copy engine placed directly upstream of the data-memory subsystem (RAM at byte addresses 0..1020, ROM at 1024 and above).
- Owns the memory port: when idle it passes CPU accesses through unchanged; when busy it moves a run of 32-bit words from a source byte address (RAM or ROM) into RAM.
- Typical use is loading a ROM data table into RAM before the processor works on it.

Parameters:
- ADDR_W, 32, address/data width.
- RAM_TOP, 1020, highest legal RAM byte address (last word).
- ROM_BASE, 1024, first ROM byte address.
- MAX_LEN, 256, maximum words per transfer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address, word aligned.
- dst_addr  in  32  destination byte address, word aligned, RAM only.
- len  in  9  number of words, legal range 1..MAX_LEN.
- cpu_a  in  32  CPU address, passed through when idle.
- cpu_we  in  1  CPU write enable.
- cpu_wd  in  32  CPU write data.
- mem_a  out  32  address to the memory block.
- mem_we  out  1  write enable to the memory block.
- mem_wd  out  32  write data to the memory block.
- mem_rd  in  32  combinational read data from the memory block.
- busy  out  1  high while the transfer is running (READ/WRITE).
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, err=0, internal counters/registers = 0. Mux selects CPU, so the CPU bus reaches memory during reset.
  - Reset mid-transfer aborts at once. Words already written stay written; no done is issued.
- States:
  - IDLE: mem_a/mem_we/mem_wd = cpu_a/cpu_we/cpu_wd (combinational). On start=1, validate the request:
    - Legal: latch src, dst, remaining=len; go to READ.
    - Illegal: err=1 next cycle; stay IDLE.
  - READ: mem_a=src_cur, mem_we=0. At the clock edge, capture mem_rd into data_q; go to WRITE.
  - WRITE: mem_a=dst_cur, mem_we=1, mem_wd=data_q. At the clock edge: src_cur+=4, dst_cur+=4, remaining-=1.
    - remaining was 1: go to DONE.
    - Otherwise: go to READ.
  - DONE: done=1 for one cycle, mux already back to CPU; go to IDLE.
- Rejection rules (any one triggers err): len==0; len>MAX_LEN; src[1:0]!=0; dst[1:0]!=0; dst+4*(len-1) > RAM_TOP (this covers a dst in the ROM region).
  - Compute the end address in 34 bits so it cannot wrap.
  - Source range is not checked. Source addresses beyond the mapped memory return whatever memory returns.
- Timing: 2 cycles per word. done rises 2*len+1 cycles after the start edge. busy=1 for exactly 2*len cycles.
- CPU cpu_* inputs are ignored while busy; the CPU stalls on busy (stall logic is outside this block). start while busy is ignored, with no err.
- Copy order is forward (ascending). Overlapping ranges with dst>src propagate already-copied words; this is defined behaviour and callers avoid it.
- done and err are registered outputs; both never high together.

Decomposition:
- Shared package mem_map_pkg:
  - constants RAM_TOP, ROM_BASE, MAX_LEN, WORD_BYTES=4;
  - enum dma_state_t {IDLE, READ, WRITE, DONE};
  - function in_ram(addr).
- Optional sub-module mem_port_mux: 2:1 selection of {a, we, wd} between the CPU and the engine, controlled by busy. Keep it in the same file otherwise.

Test Plan:
- Reset, then start with src=1024, dst=0, len=4 (ROM words 0..3 = 0xA,0xB,0xC,0xD) -> RAM[0..3]=0xA..0xD; done pulses 9 cycles after start; busy high 8 cycles; mem_we high only in WRITE cycles.
- len=256, src=1024, dst=0 -> all 256 RAM words equal the ROM; last write to byte address 1020; done after 513 cycles.
- Illegal requests: dst=1024 len=1; dst=1016 len=3; len=0; src=1026 -> each gives err one cycle later, no mem_we ever asserted, busy stays 0.
- While idle, cpu_a=8, cpu_we=1, cpu_wd=0x55 -> mem_a=8, mem_we=1, RAM[2]=0x55. While busy, CPU writes never reach memory.
- Assert reset low during the 3rd word's WRITE of a len=8 copy -> busy=0 and mem_we=0 immediately; no done; words 0..1 copied; after reset release, a new start succeeds.
- start asserted again while busy, with different addresses -> ignored; the original transfer completes with the original values.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and state type for the block-copy engine.
// RAM occupies byte addresses 0..RAM_TOP, ROM starts at ROM_BASE.
package mem_map_pkg;

  localparam int RAM_TOP    = 1020;
  localparam int ROM_BASE   = 1024;
  localparam int MAX_LEN    = 256;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dma_state_t;

  // Takes a 34-bit address so callers can test an end address that may exceed 32 bits.
  function automatic logic in_ram(input logic [33:0] addr);
    return addr <= 34'(RAM_TOP);
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// 2:1 selector of the memory request bus {a, we, wd} between CPU and copy engine.
module mem_port_mux #(
  parameter int W = 32
) (
  input  logic         sel_eng,
  input  logic [W-1:0] cpu_a,
  input  logic         cpu_we,
  input  logic [W-1:0] cpu_wd,
  input  logic [W-1:0] eng_a,
  input  logic         eng_we,
  input  logic [W-1:0] eng_wd,
  output logic [W-1:0] mem_a,
  output logic         mem_we,
  output logic [W-1:0] mem_wd
);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign mem_a[gi]  = sel_eng ? eng_a[gi]  : cpu_a[gi];
      assign mem_wd[gi] = sel_eng ? eng_wd[gi] : cpu_wd[gi];
    end
  endgenerate

  assign mem_we = sel_eng ? eng_we : cpu_we;

endmodule

// File: rtl/mem_copy_dma.sv
// Single-channel word copy engine sitting in front of the data memory.
// Passes CPU traffic through when idle; copies len words src->dst (2 cycles/word) when busy.
module mem_copy_dma #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [8:0]        len,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_wd,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wd,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import mem_map_pkg::*;

  dma_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [ADDR_W-1:0] data_reg, data_next;
  logic [8:0]        rem_reg, rem_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [33:0]       end_addr;
  logic              req_bad;
  logic [ADDR_W-1:0] eng_a;
  logic              eng_we;

  // Last destination byte address; 34 bits so a dst near the top of the space cannot wrap into RAM.
  assign end_addr = 34'(dst_addr) + (34'(len) << 2) - 34'(WORD_BYTES);

  assign req_bad = (len == 9'd0) || (len > 9'(MAX_LEN)) ||
                   (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) ||
                   !in_ram(end_addr);

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_next = 1'b1;
          end else begin
            src_next   = src_addr;
            dst_next   = dst_addr;
            rem_next   = len;
            state_next = READ;
          end
        end
      end
      READ: begin
        data_next  = mem_rd;
        state_next = WRITE;
      end
      WRITE: begin
        src_next   = src_reg + ADDR_W'(WORD_BYTES);
        dst_next   = dst_reg + ADDR_W'(WORD_BYTES);
        rem_next   = rem_reg - 9'd1;
        state_next = (rem_reg == 9'd1) ? DONE : READ;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      data_reg  <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign busy   = (state_reg == READ) || (state_reg == WRITE);
  assign eng_a  = (state_reg == WRITE) ? dst_reg : src_reg;
  assign eng_we = (state_reg == WRITE);
  assign done   = done_reg;
  assign err    = err_reg;

  mem_port_mux #(.W(ADDR_W)) u_mux (
    .sel_eng (busy),
    .cpu_a   (cpu_a),
    .cpu_we  (cpu_we),
    .cpu_wd  (cpu_wd),
    .eng_a   (eng_a),
    .eng_we  (eng_we),
    .eng_wd  (data_reg),
    .mem_a   (mem_a),
    .mem_we  (mem_we),
    .mem_wd  (mem_wd)
  );

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural RAM/ROM around the DUT, word-level copy model,
// randomized legal copies plus directed illegal, passthrough, reset and re-start scenarios.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr, cpu_a, cpu_wd, mem_a, mem_wd, mem_rd;
  logic [8:0]  len;
  logic        cpu_we, mem_we, busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram     [256] = '{default: 32'h0};
  logic [31:0] rom     [256];
  logic [31:0] exp_ram [256] = '{default: 32'h0};
  int          wr_count = 0;
  logic [31:0] last_wa = 32'h0;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .cpu_a(cpu_a), .cpu_we(cpu_we), .cpu_wd(cpu_wd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .done(done), .err(err)
  );

  // Memory environment: RAM 0..1023, ROM 1024..2047, anything else reads a marker.
  always_comb begin
    if (mem_a < 32'd1024)      mem_rd = ram[mem_a[9:2]];
    else if (mem_a < 32'd2048) mem_rd = rom[mem_a[9:2]];
    else                       mem_rd = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a < 32'd1024) ram[mem_a[9:2]] <= mem_wd;
      wr_count <= wr_count + 1;
      last_wa  <= mem_a;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd1024) return exp_ram[a[9:2]];
    if (a < 32'd2048) return rom[a[9:2]];
    return 32'hDEADBEEF;
  endfunction

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] da;
    for (int i = 0; i < n; i++) begin
      da = d + 32'(4 * i);
      exp_ram[da[9:2]] = model_read(s + 32'(4 * i));
    end
  endtask

  function automatic bit model_legal(input logic [31:0] s, input logic [31:0] d, input int n);
    longint last;
    last = longint'({32'h0, d}) + 4 * (n - 1);
    return (n >= 1) && (n <= 256) && (s[1:0] == 2'b00) && (d[1:0] == 2'b00) && (last <= 1020);
  endfunction

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) n++;
    return n;
  endfunction

  // Issues one request and follows it to done (or a cycle budget).
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          output int done_cyc, output int busy_cyc, output int we_cyc,
                          output bit err_seen);
    done_cyc = -1; busy_cyc = 0; we_cyc = 0; err_seen = 1'b0;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = 9'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cyc++;
    if (mem_we) we_cyc++;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (err) err_seen = 1'b1;
      if (done) begin done_cyc = c; break; end
      if (busy) busy_cyc++;
      if (mem_we) we_cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    cpu_a = 32'h10; cpu_we = 1'b0; cpu_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("[TB] FAIL reset_outputs busy=%b done=%b err=%b required 0/0/0", busy, done, err);
    cpu_a = $urandom & 32'h3FC; cpu_wd = $urandom;
    #1;
    tests++;
    if (mem_a !== cpu_a || mem_we !== 1'b0 || mem_wd !== cpu_wd)
      $display("[TB] FAIL reset_passthrough mem_a=%h we=%b wd=%h required %h 0 %h",
               mem_a, mem_we, mem_wd, cpu_a, cpu_wd);
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    int dc, bc, wc; bit es;
    rom[0] = 32'hA; rom[1] = 32'hB; rom[2] = 32'hC; rom[3] = 32'hD;
    model_copy(32'd1024, 32'd0, 4);
    run_copy(32'd1024, 32'd0, 4, dc, bc, wc, es);
    tests++;
    if (dc != 9) begin fails++; $display("[TB] FAIL basic_done_cycle got %0d required 9", dc); end
    tests++;
    if (bc != 8) begin fails++; $display("[TB] FAIL basic_busy_cycles got %0d required 8", bc); end
    tests++;
    if (wc != 4) begin fails++; $display("[TB] FAIL basic_we_cycles got %0d required 4", wc); end
    tests++;
    if (ram_diffs() != 0 || es) begin
      fails++; $display("[TB] FAIL basic_ram diffs=%0d err_seen=%b ram0..3=%h %h %h %h required a b c d",
                        ram_diffs(), es, ram[0], ram[1], ram[2], ram[3]);
    end
    $display("[TB] copy src=1024 dst=0 len=4 done_cyc=%0d busy=%0d we=%0d", dc, bc, wc);
  endtask

  task automatic test_full();
    int dc, bc, wc; bit es;
    model_copy(32'd1024, 32'd0, 256);
    run_copy(32'd1024, 32'd0, 256, dc, bc, wc, es);
    tests++;
    if (dc != 513) begin fails++; $display("[TB] FAIL full_done_cycle got %0d required 513", dc); end
    tests++;
    if (bc != 512 || wc != 256) begin
      fails++; $display("[TB] FAIL full_busy_we busy=%0d we=%0d required 512 256", bc, wc);
    end
    tests++;
    if (last_wa !== 32'd1020) begin fails++; $display("[TB] FAIL full_last_addr got %0d required 1020", last_wa); end
    tests++;
    if (ram_diffs() != 0 || es) begin fails++; $display("[TB] FAIL full_ram diffs=%0d err_seen=%b required 0 0", ram_diffs(), es); end
    $display("[TB] copy src=1024 dst=0 len=256 done_cyc=%0d last_wa=%0d", dc, last_wa);
  endtask

  task automatic test_illegal();
    logic [31:0] t_src [8];
    logic [31:0] t_dst [8];
    int          t_len [8];
    int          w0;
    bit          exp_err;
    t_src = '{32'd1024, 32'd1024, 32'd1024, 32'd1026, 32'd1024, 32'd1024, 32'd1024, 32'd1024};
    t_dst = '{32'd1024, 32'd1016, 32'd0,    32'd0,    32'd2,    32'd0,    32'hFFFFFFFC, 32'd4};
    t_len = '{1, 3, 0, 1, 1, 257, 2, 256};
    t_len[5] = $urandom_range(257, 511);
    for (int i = 0; i < 8; i++) begin
      exp_err = !model_legal(t_src[i], t_dst[i], t_len[i]);
      w0 = wr_count;
      @(negedge clk);
      src_addr = t_src[i]; dst_addr = t_dst[i]; len = 9'(t_len[i]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (err !== exp_err || busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("[TB] FAIL illegal_%0d err=%b busy=%b done=%b required %b 0 0", i, err, busy, done, exp_err);
      end
      @(posedge clk); #1;
      tests++;
      if (err !== 1'b0 || busy !== 1'b0 || wr_count != w0) begin
        fails++; $display("[TB] FAIL illegal_after_%0d err=%b busy=%b writes=%0d required 0 0 0",
                          i, err, busy, wr_count - w0);
      end
      $display("[TB] reject src=%0d dst=%h len=%0d err=%b", t_src[i], t_dst[i], t_len[i], exp_err);
    end
  endtask

  task automatic test_cpu_passthrough();
    int dc = -1;
    @(negedge clk);
    cpu_a = 32'd8; cpu_we = 1'b1; cpu_wd = 32'h55;
    #1;
    tests++;
    if (mem_a !== 32'd8 || mem_we !== 1'b1 || mem_wd !== 32'h55) begin
      fails++; $display("[TB] FAIL cpu_idle_bus a=%0d we=%b wd=%h required 8 1 55", mem_a, mem_we, mem_wd);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    exp_ram[2] = 32'h55;
    tests++;
    if (ram[2] !== 32'h55) begin fails++; $display("[TB] FAIL cpu_idle_write ram2=%h required 55", ram[2]); end
    $display("[TB] cpu write a=8 wd=55");
    // CPU keeps writing while a copy runs; none of it may land.
    model_copy(32'd1040, 32'h40, 3);
    @(negedge clk);
    src_addr = 32'd1040; dst_addr = 32'h40; len = 9'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cpu_a = 32'h300; cpu_we = 1'b1; cpu_wd = 32'hBAD0BAD0;
    #1;
    tests++;
    if (mem_a !== 32'd1040 || mem_we !== 1'b0) begin
      fails++; $display("[TB] FAIL cpu_busy_bus a=%0d we=%b required 1040 0", mem_a, mem_we);
    end
    repeat (4) @(posedge clk);
    #1;
    cpu_we = 1'b0;
    for (int c = 5; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin dc = c; break; end
    end
    tests++;
    if (dc != 7 || ram_diffs() != 0) begin
      fails++; $display("[TB] FAIL cpu_busy_blocked done_cyc=%0d diffs=%0d ram[0x300]=%h required 7 0 %h",
                        dc, ram_diffs(), ram[192], exp_ram[192]);
    end
    $display("[TB] copy src=1040 dst=0x40 len=3 with cpu writes, done_cyc=%0d", dc);
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    int dc, bc, wc; bit es;
    bit done_seen = 1'b0;
    s = 32'd1024 + 32'(4 * $urandom_range(0, 200));
    @(negedge clk);
    src_addr = s; dst_addr = 32'h80; len = 9'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (mem_we !== 1'b1 || mem_a !== 32'h88) begin
      fails++; $display("[TB] FAIL midreset_pre we=%b a=%h required 1 88", mem_we, mem_a);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_abort busy=%b we=%b required 0 0", busy, mem_we);
    end
    repeat (3) begin @(posedge clk); #1; if (done) done_seen = 1'b1; end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done) done_seen = 1'b1; end
    model_copy(s, 32'h80, 2);
    tests++;
    if (done_seen || ram_diffs() != 0) begin
      fails++; $display("[TB] FAIL midreset_state done_seen=%b diffs=%0d required 0 0", done_seen, ram_diffs());
    end
    model_copy(32'd1024, 32'h80, 5);
    run_copy(32'd1024, 32'h80, 5, dc, bc, wc, es);
    tests++;
    if (dc != 11 || ram_diffs() != 0 || es) begin
      fails++; $display("[TB] FAIL midreset_restart done_cyc=%0d diffs=%0d err=%b required 11 0 0", dc, ram_diffs(), es);
    end
    $display("[TB] reset during word 2 of src=%0d len=8, restart done_cyc=%0d", s, dc);
  endtask

  task automatic test_back_to_back();
    int  dc = -1;
    bit  es = 1'b0;
    logic [31:0] s;
    s = 32'd1024 + 32'(4 * $urandom_range(0, 100));
    model_copy(s, 32'h100, 6);
    @(negedge clk);
    src_addr = s; dst_addr = 32'h100; len = 9'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    src_addr = 32'd1024; dst_addr = 32'h200; len = 9'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 32'h3; dst_addr = 32'h3;
    for (int c = 4; c <= 40; c++) begin
      @(posedge clk); #1;
      if (err) es = 1'b1;
      if (done) begin dc = c; break; end
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dc != 13 || es || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_timing done_cyc=%0d err=%b busy=%b required 13 0 0", dc, es, busy);
    end
    tests++;
    if (ram_diffs() != 0) begin fails++; $display("[TB] FAIL b2b_ram diffs=%0d required 0", ram_diffs()); end
    $display("[TB] copy src=%0d dst=0x100 len=6 with ignored restart, done_cyc=%0d", s, dc);
  endtask

  task automatic test_random();
    int dc, bc, wc, n; bit es;
    logic [31:0] s, d;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        n = 2; d = 32'd1016; s = 32'd1024 + 32'(4 * $urandom_range(0, 254));
      end else begin
        n = $urandom_range(1, 32);
        d = 32'(4 * $urandom_range(0, 256 - n));
        case ($urandom_range(0, 2))
          0:       s = 32'd1024 + 32'(4 * $urandom_range(0, 256 - n));
          1:       s = 32'(4 * $urandom_range(0, 256 - n));
          default: s = 32'd2048 + 32'(4 * $urandom_range(0, 63));
        endcase
      end
      model_copy(s, d, n);
      run_copy(s, d, n, dc, bc, wc, es);
      tests++;
      if (dc != 2 * n + 1 || bc != 2 * n || wc != n || es) begin
        fails++; $display("[TB] FAIL rand_%0d_timing done=%0d busy=%0d we=%0d err=%b required %0d %0d %0d 0",
                          k, dc, bc, wc, es, 2 * n + 1, 2 * n, n);
      end
      tests++;
      if (ram_diffs() != 0) begin fails++; $display("[TB] FAIL rand_%0d_ram diffs=%0d required 0", k, ram_diffs()); end
      $display("[TB] copy src=%0d dst=%0d len=%0d done_cyc=%0d", s, d, n, dc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    // Reset checks above count failures locally via display; fold them in here.
    test_basic();
    test_full();
    test_illegal();
    test_cpu_passthrough();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Reset-phase comparisons count their own failures here so the summary sees them.
  always @(posedge clk) begin
    if (tests <= 2 && reset === 1'b0 && (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)) begin
      fails <= fails + 1;
      $display("[TB] FAIL reset_hold busy=%b done=%b err=%b required 0/0/0", busy, done, err);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
